bnn_stream_accum: RTL
=====================

// Module: bnn_stream_accum
// PURPOSE
//  Multi-word XNOR-popcount accumulator for binarised layers wider than one register.
//  Accepts a stream of operand word pairs on a valid/ready handshake.
//  Applies XNOR to each pair and popcounts it, masking the final partial word.
//  Emits one 2*pop-size (or thresholded 0/1) result per matrix. Sits beside the ALU in EX.
// PARAMETERS
//  WORD_W    32     operand word width (bits per accepted beat)
//  SIZE_W    16     matrix_size register width; max matrix = 2**SIZE_W-1 bits
//  RES_W     32     result width; signed result is sign-extended to RES_W
//  DEF_SIZE  9      matrix_size reset value
//  DEF_THR   0      activation_threshold reset value (signed)
// PORTS
//  clk         in   1       clock
//  reset       in   1       synchronous, active-high reset
//  flush       in   1       synchronous abort of in-flight operation (config kept)
//  cfg_ms_we   in   1       write matrix_size from cfg_wdata[SIZE_W-1:0]
//  cfg_at_we   in   1       write activation_threshold from cfg_wdata
//  cfg_wdata   in   RES_W   config write data (signed)
//  cfg_busy    out  1       high whenever state != IDLE
//  in_valid    in   1       operand beat valid
//  in_ready    out  1       block can accept a beat
//  in_a,in_b   in   WORD_W  operand words; bit i of a beat = matrix element i
//  in_thresh   in   1       threshold mode; sampled only with the first beat
//  out_valid   out  1       result valid
//  out_ready   in   1       consumer accepts result
//  out_data    out  RES_W   signed 2*pop-size, or 32'h0/32'h1 in threshold mode
// BEHAVIOUR
//  - Reset: state=IDLE, acc=0, remaining=0, out_valid=0, out_data=0, matrix_size=DEF_SIZE, thr=DEF_THR.
//  - FSM IDLE -> ACCUM -> DONE. in_ready=1 in IDLE/ACCUM, 0 in DONE; out_valid=1 only in DONE.
//  - Beat accepted when in_valid&&in_ready. First beat in IDLE does the following:
//    latches size_q=matrix_size and mode_q=in_thresh, and sets remaining=size_q.
//  - Per beat: n=min(remaining,WORD_W); acc+=popcount(~(in_a^in_b) & mask of low n bits); remaining-=n.
//  - remaining hits 0 on that beat -> DONE next cycle (1-cycle latency from last beat); else ACCUM.
//  - The beat count is ceil(size/WORD_W). Bits above n in the last beat are ignored.
//  - DONE: r=2*acc-size_q is computed in SIZE_W+2 signed bits, then sign-extended.
//    out_data = mode_q ? (r>=thr) : r, with a signed RES_W compare.
//  - DONE: out_data stable until out_valid&&out_ready, then IDLE with acc cleared the same edge.
//  - Config writes are honoured only in IDLE; while cfg_busy, writes are dropped.
//  - ms_we and at_we both high: only matrix_size updates.
//  - A matrix_size write of 0 is dropped (register retains its value).
//  - flush: next state IDLE, acc/remaining cleared, out_valid=0; config untouched.
//  - reset overrides flush. flush beats an in-flight beat or out handshake on the same cycle.
//  - No combinational path from out_ready to in_ready, nor from in_valid to out_valid.
// STRUCTURE
//  - bnn_pkg: state_e {IDLE,ACCUM,DONE}, DEF_SIZE/DEF_THR constants, and the popcount width function.
//  - Sub-module bnn_popcount: WORD_W data plus n-bit count input, giving a masked popcount.
//    It is combinational and has a parametrised width. The top level holds the FSM, counters and config registers.
// TESTING
//  1. Post-reset: one beat a=0,b=0, in_thresh=0 -> out_data=9. Repeat with in_thresh=1 -> out_data=1.
//  2. size=64; beats (a^b)=0, then 32'hFFFFFFFF -> out_data=0. Thr=0 thresh -> 1; thr=1 thresh -> 0.
//  3. size=40; two beats a=b=0 -> out_data=40 (only 8 bits of beat 2 counted). size=33, all-mismatch -> -33.
//  4. Hold out_ready=0 five cycles in DONE -> out_valid/out_data stable, in_ready=0, and a cfg_ms_we write is dropped.
//  5. ms_we&at_we with data 5 -> size=5, thr unchanged. A size write of 0 -> size stays 5.
//  6. size=64: reset (or flush) after beat 1 -> next op needs 2 fresh beats. Result excludes the aborted beat.

Source files
------------

// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared types and constants for the binarised stream accumulator
package bnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEF_SIZE = 9;
  localparam int DEF_THR  = 0;

  // Bits needed to hold a popcount of a w-bit word (0..w inclusive).
  function automatic int pop_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bnn_popcount.sv
// rtl/bnn_popcount.sv - combinational popcount of the low n_i bits of data_i
module bnn_popcount
  import bnn_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = pop_w(W)
) (
  input  logic [W-1:0]     data_i,
  input  logic [CNT_W-1:0] n_i,
  output logic [CNT_W-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < W; i++) begin
      if (data_i[i] && (CNT_W'(i) < n_i)) begin
        count_o = count_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bnn_stream_accum.sv
// rtl/bnn_stream_accum.sv - multi-word XNOR-popcount accumulator with optional threshold output
module bnn_stream_accum
  import bnn_pkg::*;
#(
  parameter int WORD_W   = 32,
  parameter int SIZE_W   = 16,
  parameter int RES_W    = 32,
  parameter int DEF_SIZE = bnn_pkg::DEF_SIZE,
  parameter int DEF_THR  = bnn_pkg::DEF_THR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              cfg_ms_we,
  input  logic              cfg_at_we,
  input  logic [RES_W-1:0]  cfg_wdata,
  output logic              cfg_busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  input  logic              in_thresh,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_data
);

  localparam int CNT_W = pop_w(WORD_W);

  state_e                   state_q;
  logic [SIZE_W-1:0]        acc_q;
  logic [SIZE_W-1:0]        rem_q;
  logic [SIZE_W-1:0]        size_q;
  logic                     mode_q;
  logic [SIZE_W-1:0]        ms_q;
  logic signed [RES_W-1:0]  thr_q;
  logic [RES_W-1:0]         out_data_q;

  logic                     beat;
  logic [SIZE_W-1:0]        eff_rem;
  logic [SIZE_W-1:0]        eff_size;
  logic                     eff_mode;
  logic [CNT_W-1:0]         n_d;
  logic [CNT_W-1:0]         pop;
  logic [SIZE_W-1:0]        acc_d;
  logic [SIZE_W-1:0]        rem_d;
  logic signed [SIZE_W+1:0] r;
  logic signed [RES_W-1:0]  r_ext;
  logic [RES_W-1:0]         res_d;

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign cfg_busy  = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign beat      = in_valid && in_ready;

  bnn_popcount #(.W(WORD_W), .CNT_W(CNT_W)) u_pop (
    .data_i  (~(in_a ^ in_b)),
    .n_i     (n_d),
    .count_o (pop)
  );

  // The first beat of an operation sees the live config rather than the latched copies.
  always_comb begin
    eff_rem  = (state_q == IDLE) ? ms_q : rem_q;
    eff_size = (state_q == IDLE) ? ms_q : size_q;
    eff_mode = (state_q == IDLE) ? in_thresh : mode_q;
    n_d      = (eff_rem >= SIZE_W'(WORD_W)) ? CNT_W'(WORD_W) : eff_rem[CNT_W-1:0];
    acc_d    = ((state_q == IDLE) ? '0 : acc_q) + SIZE_W'(pop);
    rem_d    = eff_rem - SIZE_W'(n_d);
    r        = $signed({1'b0, acc_d, 1'b0}) - $signed({2'b00, eff_size});
    r_ext    = {{(RES_W-SIZE_W-2){r[SIZE_W+1]}}, r};
    res_d    = eff_mode ? {{(RES_W-1){1'b0}}, (r_ext >= thr_q)} : r_ext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      rem_q      <= '0;
      size_q     <= '0;
      mode_q     <= 1'b0;
      out_data_q <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (beat) begin
            acc_q <= acc_d;
            rem_q <= rem_d;
            if (state_q == IDLE) begin
              size_q <= ms_q;
              mode_q <= in_thresh;
            end
            if (rem_d == '0) begin
              state_q    <= DONE;
              out_data_q <= res_d;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
            acc_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A simultaneous size+threshold write keeps only the size; a zero size is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_q  <= SIZE_W'(DEF_SIZE);
      thr_q <= RES_W'(DEF_THR);
    end else if (state_q == IDLE) begin
      if (cfg_ms_we) begin
        if (cfg_wdata[SIZE_W-1:0] != '0) begin
          ms_q <= cfg_wdata[SIZE_W-1:0];
        end
      end else if (cfg_at_we) begin
        thr_q <= cfg_wdata;
      end
    end
  end

endmodule
